// File: rtl/mux_pkg.sv
// Shared definitions for the registered N-input result selector:
// skid-buffer state encoding and the operand select function.
package mux_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_e;

  // The select function works on a fixed-pitch lane vector so it can serve
  // any instance with WIDTH <= MUX_MAX_W and NUM_IN <= MUX_MAX_IN.
  localparam int MUX_MAX_W   = 64;
  localparam int MUX_MAX_IN  = 16;
  localparam int MUX_LANES_W = MUX_MAX_W * MUX_MAX_IN;

  // Returns {err, data}: lane[sel] when sel < num_in, else {1, dflt}.
  function automatic logic [MUX_MAX_W:0] mux_select(
    input logic [MUX_LANES_W-1:0] lanes,
    input int unsigned            sel,
    input int unsigned            num_in,
    input logic [MUX_MAX_W-1:0]   dflt
  );
    logic [MUX_MAX_W:0] r_res;
    r_res = {1'b1, dflt};
    for (int unsigned k = 0; k < MUX_MAX_IN; k++) begin
      if ((k < num_in) && (sel == k)) begin
        r_res = {1'b0, lanes[k*MUX_MAX_W +: MUX_MAX_W]};
      end
    end
    return r_res;
  endfunction

endpackage

// File: rtl/mux_skid_buffer.sv
// Two-entry valid/ready output stage: a main register driving the
// downstream port and a skid register that absorbs one beat while the
// downstream side stalls. in_ready is registered.
//
// state | meaning
// EMPTY | nothing buffered, out_valid=0, in_ready=1
// ONE   | main holds a beat, out_valid=1, in_ready=1
// TWO   | main and skid both hold beats, out_valid=1, in_ready=0
module mux_skid_buffer
  import mux_pkg::*;
#(
  parameter int PAY_W = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PAY_W-1:0] in_payload,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [PAY_W-1:0] out_payload,
  output logic             out_valid,
  input  logic             out_ready
);

  skid_state_e      r_state;
  logic [PAY_W-1:0] r_main;
  logic [PAY_W-1:0] r_skid;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             w_accept;

  assign w_accept    = in_valid & r_in_ready;
  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign out_payload = r_main;

  // Occupancy FSM with registered handshake outputs; skid drains into main.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= EMPTY;
      r_main      <= '0;
      r_skid      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            r_main      <= in_payload;
            r_state     <= ONE;
            r_out_valid <= 1'b1;
          end
        end
        ONE: begin
          if (w_accept && out_ready) begin
            r_main <= in_payload;
          end else if (w_accept) begin
            r_skid     <= in_payload;
            r_state    <= TWO;
            r_in_ready <= 1'b0;
          end else if (out_ready) begin
            r_state     <= EMPTY;
            r_out_valid <= 1'b0;
          end
        end
        TWO: begin
          if (out_ready) begin
            r_main     <= r_skid;
            r_state    <= ONE;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= EMPTY;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/mux_n_pipe.sv
// Registered N-input result selector with a valid/ready skid output stage.
// Out-of-range selects return DEFAULT_VALUE, raise out_sel_err with the
// beat and bump a saturating error counter.
// Optional: define MUX_ZERO_FLAG_EN to add out_zero (beat data == 0),
// carried through the skid buffer alongside the beat.
module mux_n_pipe
  import mux_pkg::*;
#(
  parameter int               WIDTH         = 32,
  parameter int               NUM_IN        = 4,
  parameter int               SEL_W         = 2,
  parameter logic [WIDTH-1:0] DEFAULT_VALUE = '0,
  parameter int               ERRCNT_W      = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_sel_err,
  output logic                    out_valid,
  input  logic                    out_ready,
`ifdef MUX_ZERO_FLAG_EN
  output logic                    out_zero,
`endif
  output logic [ERRCNT_W-1:0]     err_count
);

`ifdef MUX_ZERO_FLAG_EN
  localparam int PAY_W = WIDTH + 2;
`else
  localparam int PAY_W = WIDTH + 1;
`endif

  logic [MUX_LANES_W-1:0] w_lanes;
  logic [MUX_MAX_W:0]     w_sel_res;
  logic [WIDTH-1:0]       w_data;
  logic                   w_err;
  logic                   w_accept;
  logic                   w_in_ready;
  logic                   w_unused_sel;
  logic [PAY_W-1:0]       w_pay_in;
  logic [PAY_W-1:0]       w_pay_out;
  logic [ERRCNT_W-1:0]    r_err_count;

  // Spread the packed operands onto the fixed lane pitch the selector uses.
  always_comb begin
    w_lanes = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      w_lanes[k*MUX_MAX_W +: WIDTH] = in_data[k*WIDTH +: WIDTH];
    end
  end

  assign w_sel_res    = mux_select(w_lanes, 32'(in_sel), NUM_IN, MUX_MAX_W'(DEFAULT_VALUE));
  assign w_data       = w_sel_res[WIDTH-1:0];
  assign w_err        = w_sel_res[MUX_MAX_W];
  // Lane bits above WIDTH are always zero; fold them here to keep them referenced.
  assign w_unused_sel = ^w_sel_res;
  assign w_accept     = in_valid & w_in_ready;

`ifdef MUX_ZERO_FLAG_EN
  assign w_pay_in = {(w_data == '0), w_err, w_data};
  assign {out_zero, out_sel_err, out_data} = w_pay_out;
`else
  assign w_pay_in = {w_err, w_data};
  assign {out_sel_err, out_data} = w_pay_out;
`endif

  mux_skid_buffer #(
    .PAY_W(PAY_W)
  ) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_payload (w_pay_in),
    .in_valid   (in_valid),
    .in_ready   (w_in_ready),
    .out_payload(w_pay_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  // Count accepted out-of-range beats, sticking at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_count <= '0;
    end else if (w_accept && w_err && (r_err_count != '1)) begin
      r_err_count <= r_err_count + ERRCNT_W'(1);
    end
  end

  assign in_ready  = w_in_ready;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_mux_n_pipe.sv
// Bench for mux_n_pipe: two instances share one stimulus stream.
// dut_a: NUM_IN=4, DEFAULT_VALUE=0; dut_b: NUM_IN=3, DEFAULT_VALUE=0xDEAD.
// Expected beats are queued on accept and compared while presented.
module tb_mux_n_pipe;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
    logic        zero;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] in_data;
  logic [1:0]   in_sel;
  logic         in_valid;
  logic         out_ready;

  logic         in_ready_a, out_sel_err_a, out_valid_a;
  logic [31:0]  out_data_a;
  logic [7:0]   err_count_a;
  logic         in_ready_b, out_sel_err_b, out_valid_b;
  logic [31:0]  out_data_b;
  logic [7:0]   err_count_b;
`ifdef MUX_ZERO_FLAG_EN
  logic         out_zero_a, out_zero_b;
`endif

  beat_t        qa[$];
  beat_t        qb[$];
  logic [7:0]   cnt_a, cnt_b;
  int           checks   = 0;
  int           failures = 0;
  int           xfer_a   = 0;
  int           acc_n    = 0;
  logic         last_acc;
  logic [127:0] base_data;
  int           idx;

  always #5 clk = ~clk;

  mux_n_pipe #(
    .WIDTH(32), .NUM_IN(4), .SEL_W(2), .DEFAULT_VALUE(32'h0), .ERRCNT_W(8)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready_a), .out_data(out_data_a),
    .out_sel_err(out_sel_err_a), .out_valid(out_valid_a), .out_ready(out_ready),
`ifdef MUX_ZERO_FLAG_EN
    .out_zero(out_zero_a),
`endif
    .err_count(err_count_a)
  );

  mux_n_pipe #(
    .WIDTH(32), .NUM_IN(3), .SEL_W(2), .DEFAULT_VALUE(32'hDEAD), .ERRCNT_W(8)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(in_data[95:0]), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready_b), .out_data(out_data_b),
    .out_sel_err(out_sel_err_b), .out_valid(out_valid_b), .out_ready(out_ready),
`ifdef MUX_ZERO_FLAG_EN
    .out_zero(out_zero_b),
`endif
    .err_count(err_count_b)
  );

  function automatic beat_t model(input logic [127:0] d, input logic [1:0] s,
                                  input int n, input logic [31:0] dflt);
    beat_t b;
    if (int'(s) < n) begin
      b.data = d[int'(s)*32 +: 32];
      b.err  = 1'b0;
    end else begin
      b.data = dflt;
      b.err  = 1'b1;
    end
    b.zero = (b.data == 32'h0);
    return b;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: compare at the falling edge, update the scoreboard, then
  // return 1 time unit after the rising edge so stimulus can change.
  task automatic cycle();
    beat_t ea, eb;
    @(negedge clk);
    last_acc = in_valid && (qa.size() < 2);
    chk("in_ready_a", 64'(in_ready_a), 64'(qa.size() < 2));
    chk("in_ready_b", 64'(in_ready_b), 64'(qb.size() < 2));
    chk("out_valid_a", 64'(out_valid_a), 64'(qa.size() > 0));
    chk("out_valid_b", 64'(out_valid_b), 64'(qb.size() > 0));
    chk("err_count_a", 64'(err_count_a), 64'(cnt_a));
    chk("err_count_b", 64'(err_count_b), 64'(cnt_b));
    if (qa.size() > 0) begin
      chk("data_a", 64'(out_data_a), 64'(qa[0].data));
      chk("sel_err_a", 64'(out_sel_err_a), 64'(qa[0].err));
`ifdef MUX_ZERO_FLAG_EN
      chk("zero_a", 64'(out_zero_a), 64'(qa[0].zero));
`endif
    end
    if (qb.size() > 0) begin
      chk("data_b", 64'(out_data_b), 64'(qb[0].data));
      chk("sel_err_b", 64'(out_sel_err_b), 64'(qb[0].err));
`ifdef MUX_ZERO_FLAG_EN
      chk("zero_b", 64'(out_zero_b), 64'(qb[0].zero));
`endif
    end
    if (out_valid_a && out_ready) xfer_a++;
    if (out_ready && qa.size() > 0) void'(qa.pop_front());
    if (out_ready && qb.size() > 0) void'(qb.pop_front());
    if (last_acc) begin
      acc_n++;
      ea = model(in_data, in_sel, 4, 32'h0);
      eb = model(in_data, in_sel, 3, 32'hDEAD);
      qa.push_back(ea);
      qb.push_back(eb);
      if (ea.err && cnt_a != 8'hFF) cnt_a++;
      if (eb.err && cnt_b != 8'hFF) cnt_b++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 20 && (qa.size() > 0 || qb.size() > 0); k++) cycle();
    chk("drained_a", 64'(qa.size()), 64'(0));
    chk("drained_b", 64'(qb.size()), 64'(0));
  endtask

  task automatic check_reset_state();
    chk("rst_out_valid_a", 64'(out_valid_a), 64'(0));
    chk("rst_out_valid_b", 64'(out_valid_b), 64'(0));
    chk("rst_in_ready_a", 64'(in_ready_a), 64'(1));
    chk("rst_in_ready_b", 64'(in_ready_b), 64'(1));
    chk("rst_err_count_a", 64'(err_count_a), 64'(0));
    chk("rst_err_count_b", 64'(err_count_b), 64'(0));
    chk("rst_out_data_a", 64'(out_data_a), 64'(0));
    chk("rst_sel_err_b", 64'(out_sel_err_b), 64'(0));
`ifdef MUX_ZERO_FLAG_EN
    chk("rst_zero_a", 64'(out_zero_a), 64'(0));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_data   = '0;
    in_sel    = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cnt_a     = '0;
    cnt_b     = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state();
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic select: sel=2 gives lane 2 one cycle later.
    base_data = {32'h44, 32'h33, 32'h22, 32'h11};
    in_data   = base_data;
    in_sel    = 2'd2;
    in_valid  = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk("basic_valid", 64'(out_valid_a), 64'(1));
    chk("basic_data", 64'(out_data_a), 64'(32'h33));
    chk("basic_err", 64'(out_sel_err_a), 64'(0));
    cycle();

    // sel=3: valid lane on dut_a, out of range on dut_b.
    in_sel   = 2'd3;
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk("oor_data_b", 64'(out_data_b), 64'(32'hDEAD));
    chk("oor_err_b", 64'(out_sel_err_b), 64'(1));
    chk("oor_data_a", 64'(out_data_a), 64'(32'h44));
    cycle();
    chk("oor_count_b", 64'(err_count_b), 64'(1));
    drain();

    // Back-pressure: stall with two beats buffered, junk on the bus while
    // in_ready is low, then release.
    out_ready = 1'b0;
    idx = 0;
    for (int k = 0; k < 40 && idx < 4; k++) begin
      in_sel   = 2'(idx);
      in_valid = 1'b1;
      if (k == 2 || k == 3) in_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      else in_data = base_data;
      if (k == 4) out_ready = 1'b1;
      cycle();
      if (k == 3) chk("bp_in_ready_low", 64'(in_ready_a), 64'(0));
      if (last_acc) idx++;
    end
    chk("bp_all_accepted", 64'(idx), 64'(4));
    drain();
    chk("bp_count_b", 64'(err_count_b), 64'(2));

    // Zero operand and a value of one.
    in_data  = {32'h7, 32'h0, 32'h1, 32'h0};
    in_valid = 1'b1;
    in_sel   = 2'd0;
    cycle();
    in_sel = 2'd1;
    cycle();
    in_sel = 2'd2;
    cycle();
    drain();

    // Throughput: 100 random beats, downstream always ready.
    xfer_a = 0;
    acc_n  = 0;
    out_ready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      in_sel   = 2'($urandom_range(0, 3));
      in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
      in_valid = 1'b1;
      cycle();
    end
    in_valid = 1'b0;
    cycle();
    chk("tput_accepts", 64'(acc_n), 64'(100));
    chk("tput_outputs", 64'(xfer_a), 64'(100));
    drain();

    // Saturation: 300 out-of-range beats on dut_b.
    in_data = base_data;
    in_sel  = 2'd3;
    in_valid = 1'b1;
    for (int k = 0; k < 300; k++) cycle();
    drain();
    chk("sat_count_b", 64'(err_count_b), 64'(8'hFF));

    // Reset mid-stream with two beats buffered and out_valid high.
    out_ready = 1'b0;
    in_sel    = 2'd1;
    in_valid  = 1'b1;
    cycle();
    cycle();
    chk("pre_rst_valid", 64'(out_valid_a), 64'(1));
    rst_n = 1'b0;
    #2;
    check_reset_state();
    qa.delete();
    qb.delete();
    cnt_a    = '0;
    cnt_b    = '0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Traffic resumes normally after reset.
    out_ready = 1'b1;
    in_sel    = 2'd2;
    in_valid  = 1'b1;
    cycle();
    in_sel = 2'd3;
    cycle();
    drain();
    chk("post_rst_count_b", 64'(err_count_b), 64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
